mcycle_seq_muldiv: RTL and testbench
====================================

Name: mcycle_seq_muldiv

Overview:
Multi-cycle responder for the processor's Start/Busy multiply-divide handshake.
- The core raises Start with an op select and two operands.
- This block asserts Busy in the same cycle and computes iteratively, one bit per cycle: shift-add multiply or restoring divide.
- It then drops Busy for exactly one cycle with the result valid. The core uses that cycle to write back and advance PC.
- Sits beside the ALU; operands come from register-file read ports.

Parameters:
WIDTH, 32, operand/result width in bits (>=4).
CNT_W, $clog2(WIDTH), iteration counter width (derived, not overridden).

Ports:
CLK  input  1  clock, all state on rising edge.
Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
Start  input  1  request; sampled only in IDLE.
MCycleOp  input  1  0 = unsigned multiply, 1 = unsigned divide.
Operand1  input  WIDTH  multiplicand / dividend.
Operand2  input  WIDTH  multiplier / divisor.
Result  output  WIDTH  product low half / quotient (registered).
ResultHi  output  WIDTH  product high half / remainder (registered).
Busy  output  1  stall request to core.

Behaviour:
- States: IDLE, COMPUTING, DONE.
- Reset (Reset=0, async): state=IDLE, counter=0, Result=0, ResultHi=0. Busy forced 0 while Reset=0. Reset mid-operation aborts; the partial result is discarded.
- IDLE:
  - Busy = Start (combinational). Stall takes effect in the request cycle.
  - Start=1: latch Operand1, Operand2, MCycleOp; clear working registers; counter=0; go to COMPUTING.
  - Start=0: stay in IDLE.
- COMPUTING:
  - Busy=1; one iteration per cycle; Start and operand inputs are ignored.
  - At counter==WIDTH-1 the final step is written and the next state is DONE; otherwise counter+1.
- DONE:
  - Busy=0; Result/ResultHi hold the final values; next state is IDLE unconditionally.
  - Start still high in DONE is ignored. The core drops it when PC advances.
- Latency: Busy high for WIDTH+1 cycles (request cycle + WIDTH iterations), then 1 DONE cycle. Back-to-back ops: next Start is accepted in the first IDLE cycle after DONE.
- Result/ResultHi update only on the COMPUTING->DONE transition and hold until the next completion. They are not cleared by a new Start.
- Multiply:
  - 2*WIDTH accumulator {hi,lo}, lo initialised with the multiplier.
  - Each step: if lo[0], hi += multiplicand, with the carry kept in a WIDTH+1 add. Then shift {carry,hi,lo} right 1.
  - Result = low WIDTH bits; ResultHi = high WIDTH bits; exact unsigned product.
- Divide:
  - Restoring divide; remainder register WIDTH+1 bits.
  - Each step: shift {rem,quot} left 1 bringing in the dividend MSB, trial-subtract the divisor, set the quotient bit if the result is non-negative, else restore.
  - Result = quotient, ResultHi = remainder.
- Divide by zero: no special path. The natural restoring result is Result = all ones and ResultHi = Operand1. Busy timing is identical.
- Operand edge cases need no special handling: 0 operands, all-ones operands, divisor > dividend (quotient 0, remainder = dividend).

Decomposition:
- Shared package holds:
  - State encoding constants: ST_IDLE=2'd0, ST_COMPUTING=2'd1, ST_DONE=2'd2.
  - Op codes: MCOP_MUL=1'b0, MCOP_DIV=1'b1.
- One natural combinational sub-module, mcycle_step:
  - Takes the current working registers and MCycleOp.
  - Returns the next working registers for one iteration (add/shift or subtract/restore).
- Top keeps the FSM, counter, and output registers.

Test Plan:
1. Reset=0 then 1; Start=1, MCycleOp=0, 7 x 6 -> Busy=1 same cycle and 33 cycles total, then Busy=0 one cycle with Result=42, ResultHi=0.
2. Multiply 0xFFFFFFFF x 0xFFFFFFFF -> Result=0x00000001, ResultHi=0xFFFFFFFE.
3. Divide 100 / 7 -> Result=14, ResultHi=2; divide 3 / 10 -> Result=0, ResultHi=3.
4. Divide 5 / 0 -> Result=0xFFFFFFFF, ResultHi=5, same 33-cycle Busy.
5. Start an op, drive Reset=0 at iteration 10 -> Busy=0 immediately, state IDLE, Result=0. After release, a fresh 9 x 9 completes with Result=81.
6. Hold Start=1 through DONE -> no restart in DONE. Next cycle in IDLE accepts a new op (Busy=1). Operands changed mid-COMPUTING do not affect the result.

Source files
------------

// File: rtl/mcycle_seq_muldiv_pkg.sv
// rtl/mcycle_seq_muldiv_pkg.sv - shared FSM state and op-code definitions for the multi-cycle mul/div unit
package mcycle_seq_muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COMPUTING = 2'd1,
        ST_DONE      = 2'd2
    } state_e;

    localparam logic MCOP_MUL = 1'b0;
    localparam logic MCOP_DIV = 1'b1;

endpackage

// File: rtl/mcycle_seq_muldiv_step.sv
// rtl/mcycle_seq_muldiv_step.sv - one iteration of shift-add multiply or restoring divide
//
// Ports:
//   op_i  : MCOP_MUL / MCOP_DIV
//   hi_i  : product high half / partial remainder
//   lo_i  : multiplier being shifted out / dividend being shifted out (quotient shifted in)
//   b_i   : multiplicand / divisor
//   hi_o, lo_o : working registers after this iteration
module mcycle_step
    import mcycle_seq_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             op_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        hi_o   = hi_i;
        lo_o   = lo_i;
        sum    = '0;
        rem_sh = '0;
        diff   = '0;
        if (op_i == MCOP_MUL) begin
            // Carry of the add lands in bit WIDTH and is shifted down into hi.
            sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
            hi_o = sum[WIDTH:1];
            lo_o = {sum[0], lo_i[WIDTH-1:1]};
        end else begin
            // Shifted remainder needs WIDTH+1 bits; after the trial subtract
            // or restore it is always below the divisor and fits WIDTH bits.
            rem_sh = {hi_i, lo_i[WIDTH-1]};
            diff   = rem_sh - {1'b0, b_i};
            if (!diff[WIDTH]) begin
                hi_o = diff[WIDTH-1:0];
                lo_o = {lo_i[WIDTH-2:0], 1'b1};
            end else begin
                hi_o = rem_sh[WIDTH-1:0];
                lo_o = {lo_i[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mcycle_seq_muldiv.sv
// rtl/mcycle_seq_muldiv.sv - Start/Busy multi-cycle unsigned multiply/divide unit
//
// Ports:
//   CLK       : clock, rising edge
//   Reset     : asynchronous active-low reset
//   Start     : operation request, sampled only in IDLE
//   MCycleOp  : 0 = multiply, 1 = divide
//   Operand1  : multiplicand / dividend
//   Operand2  : multiplier / divisor
//   Result    : product low half / quotient (registered)
//   ResultHi  : product high half / remainder (registered)
//   Busy      : stall request; high from the request cycle through the last iteration
module mcycle_seq_muldiv
    import mcycle_seq_muldiv_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] ResultHi,
    output logic             Busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic             busy_raw;

    mcycle_step #(.WIDTH(WIDTH)) u_step (
        .op_i (op_q),
        .hi_i (hi_q),
        .lo_i (lo_q),
        .b_i  (b_q),
        .hi_o (step_hi),
        .lo_o (step_lo)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        busy_raw = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Stall must reach the core in the same cycle it asks.
                busy_raw = Start;
                if (Start) begin
                    op_d    = MCycleOp;
                    hi_d    = '0;
                    cnt_d   = '0;
                    // lo holds the operand consumed bit by bit, b the one added/subtracted.
                    b_d     = (MCycleOp == MCOP_MUL) ? Operand1 : Operand2;
                    lo_d    = (MCycleOp == MCOP_MUL) ? Operand2 : Operand1;
                    state_d = ST_COMPUTING;
                end
            end
            ST_COMPUTING: begin
                busy_raw = 1'b1;
                hi_d     = step_hi;
                lo_d     = step_lo;
                if (cnt_q == CNT_LAST) begin
                    res_d    = step_lo;
                    res_hi_d = step_hi;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= MCOP_MUL;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_q    <= '0;
            res_hi_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
        end
    end

    assign Busy     = Reset & busy_raw;
    assign Result   = res_q;
    assign ResultHi = res_hi_q;

endmodule

// File: tb/tb_mcycle_seq_muldiv.sv
// tb/tb_mcycle_seq_muldiv.sv - scoreboard testbench for mcycle_seq_muldiv
module tb_mcycle_seq_muldiv;

    localparam int W = 32;
    localparam int BUSY_CYCLES = W + 1;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        string        name;
    } exp_t;

    logic         CLK = 1'b0;
    logic         Reset;
    logic         Start;
    logic         MCycleOp;
    logic [W-1:0] Operand1;
    logic [W-1:0] Operand2;
    logic [W-1:0] Result;
    logic [W-1:0] ResultHi;
    logic         Busy;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   target = 0;
    int   busy_run = 0;
    logic busy_prev = 1'b0;

    mcycle_seq_muldiv #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .Start    (Start),
        .MCycleOp (MCycleOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result   (Result),
        .ResultHi (ResultHi),
        .Busy     (Busy)
    );

    always #5 CLK = ~CLK;

    // Monitor: a falling Busy while out of reset marks the DONE cycle.
    always @(negedge CLK) begin
        exp_t e;
        if (Busy) begin
            busy_run++;
        end else begin
            if (busy_prev && Reset) begin
                checks++;
                if (busy_run != BUSY_CYCLES) begin
                    errors++;
                    $display("FAIL busy_len: got %0d cycles, expected %0d", busy_run, BUSY_CYCLES);
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: Result=%h ResultHi=%h with empty scoreboard", Result, ResultHi);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (Result !== e.lo) begin
                        errors++;
                        $display("FAIL %s Result: got %h, expected %h", e.name, Result, e.lo);
                    end
                    checks++;
                    if (ResultHi !== e.hi) begin
                        errors++;
                        $display("FAIL %s ResultHi: got %h, expected %h", e.name, ResultHi, e.hi);
                    end
                end
                done_cnt++;
            end
            busy_run = 0;
        end
        busy_prev = Busy;
    end

    task automatic wait_done(input int tgt);
        bit seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge CLK);
            if (done_cnt >= tgt) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout: done count %0d, expected %0d", done_cnt, tgt);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the first IDLE cycle after DONE.
    task automatic do_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] elo, input logic [W-1:0] ehi, input string name);
        exp_t e;
        e.lo = elo; e.hi = ehi; e.name = name;
        exp_q.push_back(e);
        Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
        @(posedge CLK); #1;
        // Inputs are ignored while computing; scramble them.
        Start = 1'b0; MCycleOp = ~op; Operand1 = $urandom; Operand2 = $urandom;
        target++;
        wait_done(target);
        #1;
    endtask

    task automatic check_val(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    initial begin
        exp_t e;
        Reset = 1'b0; Start = 1'b1; MCycleOp = 1'b0; Operand1 = 32'd7; Operand2 = 32'd6;
        @(negedge CLK);
        check_val("reset_busy", {31'd0, Busy}, 32'd0);
        check_val("reset_result", Result, 32'd0);
        check_val("reset_resulthi", ResultHi, 32'd0);
        Start = 1'b0;
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b1;
        @(posedge CLK); #1;

        do_op(1'b0, 32'd7, 32'd6, 32'd42, 32'd0, "mul_7x6");
        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, "mul_max");
        do_op(1'b0, 32'h1234_5678, 32'h10, 32'h2345_6780, 32'h1, "mul_shift");
        do_op(1'b0, 32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, "mul_zero");
        do_op(1'b1, 32'd100, 32'd7, 32'd14, 32'd2, "div_100_7");
        do_op(1'b1, 32'd3, 32'd10, 32'd0, 32'd3, "div_3_10");
        do_op(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, "div_by_zero");
        do_op(1'b1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, "div_max_1");

        // Reset mid-operation: partial result discarded, outputs cleared.
        Start = 1'b1; MCycleOp = 1'b0; Operand1 = 32'd123; Operand2 = 32'd45;
        @(posedge CLK); #1;
        Start = 1'b0;
        repeat (10) @(posedge CLK);
        #1 Reset = 1'b0;
        @(negedge CLK);
        check_val("abort_busy", {31'd0, Busy}, 32'd0);
        check_val("abort_result", Result, 32'd0);
        check_val("abort_resulthi", ResultHi, 32'd0);
        @(posedge CLK); #1 Reset = 1'b1;
        @(negedge CLK);
        check_val("abort_idle_busy", {31'd0, Busy}, 32'd0);
        @(posedge CLK); #1;
        do_op(1'b0, 32'd9, 32'd9, 32'd81, 32'd0, "mul_after_abort");

        // Start held through DONE; operands changed mid-compute.
        e.lo = 32'd132; e.hi = 32'd0; e.name = "hold_first";
        exp_q.push_back(e);
        Start = 1'b1; MCycleOp = 1'b0; Operand1 = 32'd12; Operand2 = 32'd11;
        @(posedge CLK); #1;
        repeat (5) @(posedge CLK);
        #1 Operand1 = 32'd3; Operand2 = 32'd4;
        e.lo = 32'd12; e.hi = 32'd0; e.name = "hold_second";
        exp_q.push_back(e);
        target++;
        wait_done(target);
        #1;
        check_val("idle_accept_busy", {31'd0, Busy}, 32'd1);
        @(posedge CLK); #1;
        Start = 1'b0; Operand1 = $urandom; Operand2 = $urandom;
        target++;
        wait_done(target);
        #1;

        repeat (3) @(posedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
